vera_video_gen: RTL and testbench

VERA_VIDEO_GEN -- requirements
Module: vera_video_gen

---
 rtl/vera_video_gen.sv | 183 ++++++++++++++++++
 tb/tb_vera_video_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vera_video_gen.sv
// vera_video_gen: raster timing generator with a pixel-enable divider, blanking/sync and test video.
// Optional feature macro VERADEMO_PATTERN_EN selects four test patterns; without it active video is flat grey.
module vera_video_gen #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 15,
  parameter int CE_DIV   = 8,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scandouble,
  input  logic [1:0]  mode,
  output logic        ce_pix,
  output logic        HBlank,
  output logic        HSync,
  output logic        VBlank,
  output logic        VSync,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        frame_start,
  output logic [23:0] video
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST_NORM = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST_SD   = DIV_W'(CE_DIV / 2 - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if ((CE_DIV < 2) || ((CE_DIV % 2) != 0) || (H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_params
      $fatal(1, "vera_video_gen: CE_DIV must be even and >= 2, H_TOTAL and V_TOTAL must be <= 1024");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d, div_last;
  logic             ce_pix_q, ce_pix_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             sd_q, sd_d;
  logic             line_end, frame_end;

  logic             hblank_q, hblank_d;
  logic             hsync_q, hsync_d;
  logic             vblank_q, vblank_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;
  logic [23:0]      video_q, video_d;
  logic [23:0]      pattern;

  // The divider period only changes at the frame wrap, where div_q has just restarted at 0.
  always_comb begin
    div_last  = sd_q ? DIV_LAST_SD : DIV_LAST_NORM;
    ce_pix_d  = (div_q == div_last);
    div_d     = ce_pix_d ? '0 : div_q + DIV_W'(1);
    line_end  = ce_pix_q && (hcount_q == H_LAST);
    frame_end = line_end && (vcount_q == V_LAST);
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (ce_pix_q) begin
      hcount_d = line_end ? '0 : hcount_q + 10'd1;
    end
    if (line_end) begin
      vcount_d = frame_end ? '0 : vcount_q + 10'd1;
    end
    sd_d = frame_end ? scandouble : sd_q;
  end

  always_comb begin
    hblank_d      = (hcount_q >= H_ACT);
    vblank_d      = (vcount_q >= V_ACT);
    hsync_d       = ((hcount_q >= HS_BEGIN) && (hcount_q < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = ((vcount_q >= VS_BEGIN) && (vcount_q < VS_END)) ? VS_POL : ~VS_POL;
    frame_start_d = ce_pix_q && (hcount_q == 10'd0) && (vcount_q == 10'd0);
    video_d       = (hblank_d || vblank_d) ? 24'h000000 : pattern;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      ce_pix_q      <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      sd_q          <= 1'b0;
      hblank_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vblank_q      <= 1'b0;
      vsync_q       <= ~VS_POL;
      frame_start_q <= 1'b0;
      video_q       <= '0;
    end else begin
      div_q         <= div_d;
      ce_pix_q      <= ce_pix_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      sd_q          <= sd_d;
      hblank_q      <= hblank_d;
      hsync_q       <= hsync_d;
      vblank_q      <= vblank_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      video_q       <= video_d;
    end
  end

`ifdef VERADEMO_PATTERN_EN
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;

  // Bar index is hcount*8/H_ACTIVE, found by threshold compares instead of a divider.
  always_comb begin
    mode_d      = frame_end ? mode : mode_q;
    frame_cnt_d = frame_start_q ? frame_cnt_q + 8'd1 : frame_cnt_q;
    bar_idx     = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ({19'd0, hcount_q, 3'b000} >= 32'(i * H_ACTIVE)) begin
        bar_idx = 3'(i);
      end
    end
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    pattern = 24'h000000;
    case (mode_q)
      2'd0:    pattern = bar_rgb;
      2'd1:    pattern = ((hcount_q[3:0] == 4'd0) || (vcount_q[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
      2'd2:    pattern = {hcount_q[7:0], vcount_q[7:0], 8'h80};
      default: pattern = {3{frame_cnt_q}};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign pattern     = 24'h808080;
`endif

  assign ce_pix      = ce_pix_q;
  assign HBlank      = hblank_q;
  assign HSync       = hsync_q;
  assign VBlank      = vblank_q;
  assign VSync       = vsync_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = frame_start_q;
  assign video       = video_q;

endmodule

// File: tb/tb_vera_video_gen.sv
// tb_vera_video_gen: directed, table-driven bench for vera_video_gen on a shrunken raster.
// Pattern checks are compiled in only when VERADEMO_PATTERN_EN is defined.
module tb_vera_video_gen;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int CE_DIV   = 4;
  localparam bit HS_POL   = 1'b0;
  localparam bit VS_POL   = 1'b1;

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LINE_CLK   = H_TOTAL * CE_DIV;
  localparam int FRAME_CLK  = LINE_CLK * V_TOTAL;
  localparam int WAIT_LIMIT = 2 * FRAME_CLK + 16;

`ifdef VERADEMO_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hb;
    logic        hs;
    logic        vb;
    logic        vs;
    logic [23:0] vid_def;
    logic [23:0] vid_pat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scandouble = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        ce_pix;
  logic        HBlank;
  logic        HSync;
  logic        VBlank;
  logic        VSync;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        frame_start;
  logic [23:0] video;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  vera_video_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CE_DIV(CE_DIV), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .scandouble(scandouble),
    .mode(mode),
    .ce_pix(ce_pix),
    .HBlank(HBlank),
    .HSync(HSync),
    .VBlank(VBlank),
    .VSync(VSync),
    .hcount(hcount),
    .vcount(vcount),
    .frame_start(frame_start),
    .video(video)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sd, input logic [1:0] m);
    scandouble = sd;
    mode       = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out, got no event, expected one", name);
  endtask

  // Leaves the bench on the clk whose registered outputs describe pixel (h,v).
  task automatic waitPixel(input logic [9:0] h, input logic [9:0] v, output bit found);
    found = 1'b0;
    for (int n = 0; n < WAIT_LIMIT; n++) begin
      tick();
      if (hcount == h && vcount == v) begin
        found = 1'b1;
        break;
      end
    end
    if (found) tick();
    else timeoutFail($sformatf("wait_pixel_%0d_%0d", h, v));
  endtask

  task automatic waitFrameStart(output int unsigned t);
    bit seen;
    seen = 1'b0;
    t    = 0;
    for (int n = 0; n < WAIT_LIMIT; n++) begin
      tick();
      if (frame_start) begin
        seen = 1'b1;
        t    = cyc;
        break;
      end
    end
    if (!seen) timeoutFail("wait_frame_start");
  endtask

  task automatic measureCePeriod(output int unsigned p);
    int unsigned t0;
    bit          seen;
    p    = 0;
    t0   = 0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (ce_pix) begin
        if (seen) begin
          p = cyc - t0;
          break;
        end
        seen = 1'b1;
        t0   = cyc;
      end
    end
  endtask

  task automatic checkPixel(input string tag, input logic hb, input logic hs, input logic vb,
                            input logic vs, input logic [23:0] vid);
    checkOutput({tag, "_hblank"}, 32'(HBlank), 32'(hb));
    checkOutput({tag, "_hsync"},  32'(HSync),  32'(hs));
    checkOutput({tag, "_vblank"}, 32'(VBlank), 32'(vb));
    checkOutput({tag, "_vsync"},  32'(VSync),  32'(vs));
    checkOutput({tag, "_video"},  32'(video),  32'(vid));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ce_pix"}, 32'(ce_pix), 32'd0);
    checkOutput({tag, "_hcount"}, 32'(hcount), 32'd0);
    checkOutput({tag, "_vcount"}, 32'(vcount), 32'd0);
    checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    checkPixel(tag, 1'b0, ~HS_POL, 1'b0, ~VS_POL, 24'h000000);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected TB_RESULT first");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[14];
    int unsigned t0;
    int unsigned t1;
    int unsigned p;
    int          n;
    int          cnt;
    bit          ok;

    // {h, v, HBlank, HSync, VBlank, VSync, video (grey build), video (mode 0 bars)}
    vecs[0]  = '{10'd0,  10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h808080, 24'hFFFFFF};
    vecs[1]  = '{10'd17, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[2]  = '{10'd3,  10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h808080, 24'hFFFF00};
    vecs[3]  = '{10'd6,  10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h808080, 24'h00FF00};
    vecs[4]  = '{10'd18, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[5]  = '{10'd20, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[6]  = '{10'd21, 10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[7]  = '{10'd10, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0, 24'h808080, 24'hFF0000};
    vecs[8]  = '{10'd15, 10'd5, 1'b0, 1'b1, 1'b0, 1'b0, 24'h808080, 24'h000000};
    vecs[9]  = '{10'd16, 10'd5, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[10] = '{10'd5,  10'd6, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000};
    vecs[11] = '{10'd5,  10'd7, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 24'h000000};
    vecs[12] = '{10'd3,  10'd8, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 24'h000000};
    vecs[13] = '{10'd23, 10'd9, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000};

    applyStimulus(1'b0, 2'd0);
    repeat (3) tick();
    checkResetState("reset");

    @(negedge clk) reset_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (frame_start) begin
        n = i;
        break;
      end
    end
    checkOutput("first_frame_start_delay", 32'(n), 32'(CE_DIV + 1));

    measureCePeriod(p);
    checkOutput("ce_pix_period", p, 32'(CE_DIV));
    tick();
    checkOutput("ce_pix_width", 32'(ce_pix), 32'd0);

    waitFrameStart(t0);
    tick();
    checkOutput("frame_start_width", 32'(frame_start), 32'd0);
    waitFrameStart(t1);
    checkOutput("frame_period", t1 - t0, 32'(FRAME_CLK));

    cnt = 0;
    repeat (LINE_CLK) begin
      tick();
      if (HSync == HS_POL) cnt++;
    end
    checkOutput("hsync_active_clks", 32'(cnt), 32'(H_SYNC * CE_DIV));
    cnt = 0;
    repeat (FRAME_CLK) begin
      tick();
      if (VSync == VS_POL) cnt++;
    end
    checkOutput("vsync_active_clks", 32'(cnt), 32'(V_SYNC * LINE_CLK));

    for (int i = 0; i < 14; i++) begin
      waitPixel(vecs[i].h, vecs[i].v, ok);
      if (ok) checkPixel($sformatf("vec%0d", i), vecs[i].hb, vecs[i].hs, vecs[i].vb, vecs[i].vs,
                         PAT_EN ? vecs[i].vid_pat : vecs[i].vid_def);
    end

    // scandouble requested mid-frame: the old rate holds until the wrap
    waitFrameStart(t0);
    repeat (100) tick();
    applyStimulus(1'b1, 2'd0);
    measureCePeriod(p);
    checkOutput("sd_ce_period_before_wrap", p, 32'(CE_DIV));
    waitFrameStart(t0);
    measureCePeriod(p);
    checkOutput("sd_ce_period_after_wrap", p, 32'(CE_DIV / 2));
    waitFrameStart(t1);
    checkOutput("sd_frame_period", t1 - t0, 32'(FRAME_CLK / 2));

    // reset pulsed mid-frame while sync and blanking are all active
    waitPixel(10'd20, 10'd8, ok);
    if (ok) checkPixel("pre_reset", 1'b1, HS_POL, 1'b1, VS_POL, 24'h000000);
    @(negedge clk) reset_n = 1'b0;
    #1;
    checkResetState("async_reset");
    repeat (2) tick();
    checkResetState("held_reset");
    @(negedge clk) reset_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (frame_start) begin
        n = i;
        break;
      end
    end
    checkOutput("restart_frame_start_delay", 32'(n), 32'(CE_DIV + 1));

`ifdef VERADEMO_PATTERN_EN
    // frames counted from the release: frame_cnt equals the frame number
    applyStimulus(1'b0, 2'd1);
    waitFrameStart(t0);
    waitPixel(10'd0, 10'd2, ok);
    if (ok) checkOutput("grid_0_2", 32'(video), 32'h00FFFFFF);
    waitPixel(10'd5, 10'd3, ok);
    if (ok) checkOutput("grid_5_3", 32'(video), 32'h00000000);
    waitPixel(10'd2, 10'd4, ok);
    applyStimulus(1'b0, 2'd2);
    waitPixel(10'd0, 10'd5, ok);
    if (ok) checkOutput("grid_after_switch_0_5", 32'(video), 32'h00FFFFFF);
    waitPixel(10'd5, 10'd5, ok);
    if (ok) checkOutput("grid_after_switch_5_5", 32'(video), 32'h00000000);
    waitFrameStart(t0);
    waitPixel(10'd0, 10'd2, ok);
    if (ok) checkOutput("gradient_0_2", 32'(video), 32'h00000280);
    waitPixel(10'd5, 10'd3, ok);
    if (ok) checkOutput("gradient_5_3", 32'(video), 32'h00050380);
    applyStimulus(1'b0, 2'd3);
    waitFrameStart(t0);
    waitPixel(10'd3, 10'd1, ok);
    if (ok) checkOutput("fade_frame4", 32'(video), 32'h00040404);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
